alu_mc_sequencer: RTL and testbench

//  Sequencer in front of the 64-bit SIMD multicycle ALU (add/sub/mul-even/mul-odd, ww lane width).

---
 rtl/alu_mc_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_alu_mc_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_sequencer.sv
// rtl/alu_mc_sequencer.sv - multicycle issue/hold/capture sequencer in front of the SIMD ALU
//
// Purpose: accepts one ALU op per in_valid/in_ready handshake and latches its operands.
//   The ALU inputs are then held stable with alu_en=1 for ADD_LAT (add/sub) or MUL_LAT
//   (mul even/odd) cycles. After that the ALU result is captured and presented on the
//   out_valid/out_ready port. Unsupported op codes skip the ALU and complete at once with
//   out_illegal=1 and out_data=0.
// Parameters: ADD_LAT, MUL_LAT (1..15).
// Ports:
//   clk, reset (async active-high)
//   in_valid/in_ready, in_type[6], in_ww[2], in_imm[5], in_a/in_b[64]  op request
//   alu_en, alu_type, alu_ww, alu_imm, alu_a, alu_b                     ALU drive
//   alu_dout[64]                                                        ALU result
//   out_valid/out_ready, out_data[64], out_illegal                      result port
//   busy                                                                state != IDLE
// Build option: ALU_MC_PERF_EN adds perf_ops[32] and perf_busy[32] counters.
module alu_mc_sequencer #(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_type,
  input  logic [1:0]  in_ww,
  input  logic [4:0]  in_imm,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        alu_en,
  output logic [5:0]  alu_type,
  output logic [1:0]  alu_ww,
  output logic [4:0]  alu_imm,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_illegal,
  output logic        busy
`ifdef ALU_MC_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy
`endif
);

  if (ADD_LAT < 1 || ADD_LAT > 15) begin : g_bad_add_lat
    $error("alu_mc_sequencer: ADD_LAT must be in 1..15");
  end
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("alu_mc_sequencer: MUL_LAT must be in 1..15");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] OP_ADD  = 6'b000101;
  localparam logic [5:0] OP_SUB  = 6'b000110;
  localparam logic [5:0] OP_MULE = 6'b000111;
  localparam logic [5:0] OP_MULO = 6'b001000;

  // Counter preload: EXEC lasts cnt+1 cycles, so load LAT-1.
  localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        alu_en_q, alu_en_d;
  logic [5:0]  alu_type_q, alu_type_d;
  logic [1:0]  alu_ww_q, alu_ww_d;
  logic [4:0]  alu_imm_q, alu_imm_d;
  logic [63:0] alu_a_q, alu_a_d;
  logic [63:0] alu_b_q, alu_b_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_illegal_q, out_illegal_d;

  logic is_add;
  logic is_mul;

  assign is_add = (in_type == OP_ADD) || (in_type == OP_SUB);
  assign is_mul = (in_type == OP_MULE) || (in_type == OP_MULO);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_en_d      = alu_en_q;
    alu_type_d    = alu_type_q;
    alu_ww_d      = alu_ww_q;
    alu_imm_d     = alu_imm_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_illegal_d = out_illegal_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          alu_type_d = in_type;
          alu_ww_d   = in_ww;
          alu_imm_d  = in_imm;
          alu_a_d    = in_a;
          alu_b_d    = in_b;
          if (is_add || is_mul) begin
            state_d  = S_EXEC;
            cnt_d    = is_mul ? MUL_CNT : ADD_CNT;
            alu_en_d = 1'b1;
          end else begin
            // Unsupported code: never enable the ALU, complete immediately.
            state_d       = S_DONE;
            out_data_d    = 64'd0;
            out_illegal_d = 1'b1;
            out_valid_d   = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_data_d    = alu_dout;
          out_illegal_d = 1'b0;
          out_valid_d   = 1'b1;
          alu_en_d      = 1'b0;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        alu_en_d    = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      alu_en_q      <= 1'b0;
      alu_type_q    <= 6'd0;
      alu_ww_q      <= 2'd0;
      alu_imm_q     <= 5'd0;
      alu_a_q       <= 64'd0;
      alu_b_q       <= 64'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 64'd0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_en_q      <= alu_en_d;
      alu_type_q    <= alu_type_d;
      alu_ww_q      <= alu_ww_d;
      alu_imm_q     <= alu_imm_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign alu_en      = alu_en_q;
  assign alu_type    = alu_type_q;
  assign alu_ww      = alu_ww_q;
  assign alu_imm     = alu_imm_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_illegal = out_illegal_q;

`ifdef ALU_MC_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  always_comb begin
    perf_ops_d  = perf_ops_q + {31'd0, out_valid_q & out_ready};
    perf_busy_d = perf_busy_q + {31'd0, busy};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops_q  <= 32'd0;
      perf_busy_q <= 32'd0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_alu_mc_sequencer.sv
// tb/tb_alu_mc_sequencer.sv - self-checking bench for alu_mc_sequencer
module tb_alu_mc_sequencer;
  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_type;
  logic [1:0]  in_ww;
  logic [4:0]  in_imm;
  logic [63:0] in_a, in_b;
  logic        alu_en;
  logic [5:0]  alu_type;
  logic [1:0]  alu_ww;
  logic [4:0]  alu_imm;
  logic [63:0] alu_a, alu_b, alu_dout;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_illegal;
  logic        busy;
`ifdef ALU_MC_PERF_EN
  logic [31:0] perf_ops, perf_busy;
`endif

  int total = 0;
  int bad = 0;
  int m_ops = 0;
  int m_busy = 0;

  always #5 clk = ~clk;

  alu_mc_sequencer #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_ww(in_ww),
    .in_imm(in_imm), .in_a(in_a), .in_b(in_b),
    .alu_en(alu_en), .alu_type(alu_type), .alu_ww(alu_ww), .alu_imm(alu_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_dout(alu_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_illegal(out_illegal), .busy(busy)
`ifdef ALU_MC_PERF_EN
    , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
  );

  // Lane-wise SIMD ALU: lane 0 is the most significant lane.
  function automatic logic [63:0] lane_mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] alu_fn(input logic [5:0] t, input logic [1:0] w,
                                         input logic [63:0] a, input logic [63:0] b);
    int lw, nl, li;
    logic [63:0] r, m, x, y, p;
    lw = 8 << w;
    nl = 64 / lw;
    m  = lane_mask(lw);
    r  = 64'd0;
    if (t == 6'd5 || t == 6'd6) begin
      for (int i = 0; i < nl; i++) begin
        x = (a >> (64 - (i + 1) * lw)) & m;
        y = (b >> (64 - (i + 1) * lw)) & m;
        x = (t == 6'd5) ? x + y : x - y;
        r = r | ((x & m) << (64 - (i + 1) * lw));
      end
    end else if ((t == 6'd7 || t == 6'd8) && lw < 64) begin
      for (int j = 0; j < nl / 2; j++) begin
        li = 2 * j + ((t == 6'd8) ? 1 : 0);
        x = (a >> (64 - (li + 1) * lw)) & m;
        y = (b >> (64 - (li + 1) * lw)) & m;
        p = x * y;
        r = r | ((p & lane_mask(2 * lw)) << (64 - (j + 1) * 2 * lw));
      end
    end
    return r;
  endfunction

  assign alu_dout = alu_fn(alu_type, alu_ww, alu_a, alu_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic junk_inputs();
    in_type = 6'($urandom);
    in_ww   = 2'($urandom);
    in_imm  = 5'($urandom);
    in_a    = {$urandom, $urandom};
    in_b    = {$urandom, $urandom};
  endtask

  // One op end to end: issue, hold phase, result, hold_cycles of backpressure, release.
  // in_valid stays high with junk after acceptance to prove it is ignored.
  task automatic do_op(input logic [5:0] t, input logic [1:0] w, input logic [4:0] imm,
                       input logic [63:0] a, input logic [63:0] b, input int hold_cycles);
    logic ill;
    int lat;
    logic [63:0] exp;
    ill = !(t == 6'd5 || t == 6'd6 || t == 6'd7 || t == 6'd8);
    lat = ill ? 0 : ((t == 6'd7 || t == 6'd8) ? MUL_LAT : ADD_LAT);
    exp = ill ? 64'd0 : alu_fn(t, w, a, b);

    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_type = t; in_ww = w; in_imm = imm; in_a = a; in_b = b;
    @(posedge clk); #1;
    junk_inputs();

    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("exec_alu_en", alu_en, 1);
      chk("exec_out_valid", out_valid, 0);
      chk("exec_in_ready", in_ready, 0);
      chk("exec_busy", busy, 1);
      chk("exec_alu_a", alu_a, a);
      chk("exec_alu_b", alu_b, b);
      chk("exec_alu_type", alu_type, t);
      chk("exec_alu_ww", alu_ww, w);
      chk("exec_alu_imm", alu_imm, imm);
    end

    @(negedge clk);
    chk("res_out_valid", out_valid, 1);
    chk("res_alu_en", alu_en, 0);
    chk("res_out_data", out_data, exp);
    chk("res_out_illegal", out_illegal, ill);
    chk("res_in_ready", in_ready, 0);

    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, exp);
      chk("bp_out_illegal", out_illegal, ill);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_alu_en", alu_en, 0);
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    m_ops  += 1;
    m_busy += lat + 1 + hold_cycles;

    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_alu_en", alu_en, 0);
    chk("idle_alu_a_kept", alu_a, a);
    chk("idle_alu_type_kept", alu_type, t);
`ifdef ALU_MC_PERF_EN
    chk("perf_ops", perf_ops, 64'(m_ops));
    chk("perf_busy", perf_busy, 64'(m_busy));
`endif
  endtask

  initial begin
    logic [5:0] t;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_type = '0; in_ww = '0; in_imm = '0; in_a = '0; in_b = '0;
    #22;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_type", alu_type, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // in_valid low in IDLE: nothing happens.
    repeat (3) begin
      @(negedge clk);
      junk_inputs();
      chk("no_valid_busy", busy, 0);
      chk("no_valid_alu_en", alu_en, 0);
    end

    // Directed vectors.
    do_op(6'b000101, 2'b00, 5'd3, 64'h0102030405060708, 64'h01010101010101FF, 0);
    chk("vec_add_bytes", out_data, 64'h0203040506070807);
    do_op(6'b000110, 2'b11, 5'd0, 64'd0, 64'd1, 1);
    chk("vec_sub_64", out_data, 64'hFFFFFFFFFFFFFFFF);
    do_op(6'b000111, 2'b01, 5'd9, 64'h00FF000000020000, 64'h00FF000000030000, 0);
    chk("vec_mul_even", out_data, 64'h0000FE0100000006);
    do_op(6'b111111, 2'b10, 5'd1, 64'h1234, 64'h5678, 0);
    chk("vec_illegal_data", out_data, 0);
    // Backpressure for 10 cycles, then the next op must be accepted.
    do_op(6'b001000, 2'b00, 5'd7, 64'h0102030405060708, 64'h1111111111111111, 10);
    do_op(6'b000101, 2'b10, 5'd2, 64'hFFFFFFFF00000001, 64'h0000000100000002, 0);

    // Back-to-back adds.
    repeat (3) do_op(6'b000101, 2'b00, 5'd0, {$urandom, $urandom}, {$urandom, $urandom}, 0);

    // Randomized ops.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0: t = 6'd5;
        1: t = 6'd6;
        2: t = 6'd7;
        3: t = 6'd8;
        default: t = 6'($urandom);
      endcase
      do_op(t, 2'($urandom), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3));
    end

    // Reset in the middle of a MUL: op discarded, everything back to zero.
    @(negedge clk);
    in_valid = 1'b1; in_type = 6'd7; in_ww = 2'b01; in_imm = 5'd5;
    in_a = 64'hDEADBEEFCAFEF00D; in_b = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_alu_en", alu_en, 1);
    reset = 1'b1;
    #1;
    chk("midrst_alu_en", alu_en, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_alu_ww", alu_ww, 0);
    chk("midrst_alu_imm", alu_imm, 0);
    chk("midrst_out_data", out_data, 0);
    m_ops = 0; m_busy = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (MUL_LAT + 2) begin
      @(negedge clk);
      chk("after_rst_out_valid", out_valid, 0);
      chk("after_rst_in_ready", in_ready, 1);
    end
    do_op(6'b000110, 2'b01, 5'd4, {$urandom, $urandom}, {$urandom, $urandom}, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
